// File: rtl/stage_link_pkg.sv
// Shared types and constants for the stage_link transmitter.
// STAGE_LINK_PARITY_EN adds a trailing even-parity bit to every frame.
package stage_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

`ifdef STAGE_LINK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Counter must hold both the longest frame count and the gap length.
  function automatic int cnt_w(input int width, input int gap);
    int m;
    m = (width + 1 > gap) ? width + 1 : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stage_link_shreg.sv
// Loadable MSB-first shift register with asynchronous active-low clear.
module stage_link_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (shift) begin
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign msb = q_q[WIDTH-1];

endmodule

// File: rtl/stage_link_tx.sv
// Transmit end of the two-wire staged link: one-word hold buffer, MSB-first serializer.
// Define STAGE_LINK_PARITY_EN to append an even-parity bit after the data bits.
module stage_link_tx
  import stage_link_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             mid1,
  output logic             mid2,
  output logic             busy
);

  localparam int CW    = cnt_w(WIDTH, GAP);
  localparam int FRAME = WIDTH + PAR_BITS;
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);
  localparam logic [CW-1:0] GAP_C   = CW'(GAP);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             mid1_q, mid1_d;
  logic             mid2_q, mid2_d;
  logic             busy_q, busy_d;
  logic             load, shift, accept, sr_msb;
`ifdef STAGE_LINK_PARITY_EN
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  logic             par_q, par_d;
`endif

  // The shift register is loaded pre-shifted so its MSB is always the next bit to send.
  stage_link_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk1),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   ({hold_q[WIDTH-2:0], 1'b0}),
    .msb   (sr_msb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    mid1_d      = mid1_q;
    mid2_d      = mid2_q;
    load        = 1'b0;
    shift       = 1'b0;
    accept      = in_valid && !hold_full_q;
`ifdef STAGE_LINK_PARITY_EN
    par_d       = par_q;
`endif

    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q < FRAME_C) begin
          mid1_d = 1'b1;
          mid2_d = sr_msb;
          shift  = 1'b1;
          cnt_d  = cnt_q + ONE_C;
`ifdef STAGE_LINK_PARITY_EN
          if (cnt_q == WIDTH_C) mid2_d = par_q;
`endif
        end else begin
          mid1_d  = 1'b0;
          mid2_d  = 1'b0;
          state_d = ST_GAP;
          cnt_d   = ONE_C;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_C) begin
          if (hold_full_q) load = 1'b1;
          else             state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load never coincides with accept: one needs the hold full, the other empty.
    if (load) begin
      hold_full_d = 1'b0;
      state_d     = ST_SHIFT;
      cnt_d       = ONE_C;
      mid1_d      = 1'b1;
      mid2_d      = hold_q[WIDTH-1];
`ifdef STAGE_LINK_PARITY_EN
      par_d       = ^hold_q;
`endif
    end

    busy_d = (state_d != ST_IDLE) || hold_full_d;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      mid1_q      <= 1'b0;
      mid2_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      mid1_q      <= mid1_d;
      mid2_q      <= mid2_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk1) begin
    hold_q <= hold_d;
`ifdef STAGE_LINK_PARITY_EN
    par_q  <= par_d;
`endif
  end

  assign in_ready = !hold_full_q;
  assign mid1     = mid1_q;
  assign mid2     = mid2_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_stage_link_tx.sv
// Scoreboard bench for stage_link_tx: accepted words queue up, a negedge monitor checks the serial stream.
module tb_stage_link_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 1;
`ifdef STAGE_LINK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk1 = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, mid1, mid2, busy;

  stage_link_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mid1     (mid1),
    .mid2     (mid2),
    .busy     (busy)
  );

  always #5 clk1 = ~clk1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state
  logic [WIDTH-1:0] word_q[$];
  bit               bit_q[$];
  int               accepted = 0;
  int               started  = 0;
  bit               in_frame = 0;
  bit               had_frame = 0;
  int               idle_run = 0;
  bit               acc_last = 0;
  logic [WIDTH-1:0] cur_w;

  // Handshake sampler: a word is transferred on any edge with valid and ready.
  always @(posedge clk1) begin
    if (rst_n && in_valid && in_ready) begin
      word_q.push_back(in_data);
      accepted++;
      acc_last = 1'b1;
    end else begin
      acc_last = 1'b0;
    end
  end

  // Monitor: compares the serial stream against the expected bit sequence.
  always @(negedge clk1) begin
    if (!rst_n) begin
      word_q.delete();
      bit_q.delete();
      accepted  = 0;
      started   = 0;
      in_frame  = 0;
      had_frame = 0;
      idle_run  = 0;
    end else begin
      if (mid1 && !in_frame) begin
        if (had_frame) chk("gap_len", idle_run >= GAP, 1);
        if (word_q.size() == 0) begin
          chk("frame_without_word", 1, 0);
        end else begin
          cur_w = word_q.pop_front();
          started++;
          for (int i = WIDTH - 1; i >= 0; i--) bit_q.push_back(cur_w[i]);
          if (PAR) bit_q.push_back(^cur_w);
        end
        in_frame = 1;
      end
      if (mid1) begin
        if (bit_q.size() == 0) chk("frame_too_long", 1, 0);
        else chk("mid2_bit", mid2, bit_q.pop_front());
      end else begin
        if (in_frame) begin
          chk("frame_short", bit_q.size(), 0);
          bit_q.delete();
          in_frame  = 0;
          had_frame = 1;
          idle_run  = 0;
        end
        idle_run++;
        chk("mid2_idle", mid2, 0);
        if (accepted - started > 0)
          chk("no_stall", (had_frame && idle_run <= GAP) || acc_last, 1);
      end
      chk("in_ready", in_ready, (accepted - started) == 0);
      chk("busy", busy, (accepted - started) > 0 || mid1 || (had_frame && idle_run <= GAP));
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 200) begin
      @(negedge clk1);
      t++;
    end
    if (t >= 200) chk("send_timeout", 0, 1);
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mid1"}, mid1, 0);
    chk({tag, "_mid2"}, mid2, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int t;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_init");
    repeat (3) @(posedge clk1);
    #2 rst_n = 1'b1;
    #1 check_reset_outputs("rst_release");
    @(negedge clk1);
    idle(3);

    // Single word, then back-to-back pair
    send(8'hA5);
    idle(WIDTH + 4);
    send(8'h01);
    send(8'h80);
    idle(2 * WIDTH + 6);

    // Backpressure: data toggles while not ready must not be taken
    send(8'h5A);
    send(8'h3C);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      if (in_ready) break;
      in_data = (in_data == 8'h3C) ? 8'hC3 : 8'h3C;
    end
    in_valid = 1'b0;
    idle(2 * WIDTH + 6);

    // Reset in the middle of a frame
    send(8'hF0);
    t = 0;
    while (!mid1 && t < 20) begin
      @(negedge clk1);
      t++;
    end
    chk("frame_start_timeout", mid1, 1);
    idle(2);
    @(posedge clk1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk1);
    #2 rst_n = 1'b1;
    #1 check_reset_outputs("rst_mid_release");
    @(negedge clk1);
    idle(3);
    send(8'hFF);
    idle(WIDTH + 4);

    send(8'h07);
    idle(WIDTH + 4);

    // Randomized traffic with random idle spacing
    for (int k = 0; k < 40; k++) begin
      idle($urandom_range(0, WIDTH + 3));
      send(WIDTH'($urandom));
    end

    t = 0;
    while ((busy || word_q.size() != 0) && t < 400) begin
      @(negedge clk1);
      t++;
    end
    chk("drain_timeout", t < 400, 1);
    chk("drain_words", word_q.size(), 0);
    chk("drain_accept_count", accepted, started);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
